pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Generic parametrised inter-stage pipeline register for the 5-stage CPU. It replaces the hand-written per-stage registers (IF/ID, ID/EX, ...) with one block instantiated per boundary. The stall-vector index and payload width are parameters. Adds a per-entry valid bit, a flush input, and a saturating consecutive-hold counter for stall watchdog and debug. It sits between stage STAGE and stage STAGE+1, driven by the central stall controller.

Parameters:
STAGE, 1, stall-vector bit owned by the producing stage; this block also reads bit STAGE+1; legal range 0..STALL_W-2
STALL_W, 6, width of the stall vector from the stall controller
PAYLOAD_W, 32, width of the opaque payload (instruction word, decoded fields, ...)
HOLD_W, 8, width of the consecutive-hold counter

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
stall  in  STALL_W  stall vector; bit = 1 means Stop, 0 means NoStop
flush  in  1  exception/branch flush; kills the entry held in this register
i_valid  in  1  producing stage holds a real instruction
i_pc  in  32  producing stage PC
i_payload  in  PAYLOAD_W  producing stage payload
o_valid  out  1  registered valid bit
o_pc  out  32  registered PC
o_payload  out  PAYLOAD_W  registered payload
o_hold_cnt  out  HOLD_W  consecutive cycles the entry has been held; saturates
o_bubble_cnt  out  32  bubbles inserted (feature-gated)
o_flush_cnt  out  32  flushes taken (feature-gated)

Behaviour:
- Clock is clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values: o_valid=0, o_pc=0, o_payload=0, o_hold_cnt=0, o_bubble_cnt=0, o_flush_cnt=0.
- Let s_prod = stall[STAGE] and s_cons = stall[STAGE+1]. Each cycle exactly one action applies, in this priority order:
  1. reset: load reset values.
  2. flush=1: BUBBLE action. This overrides any stall.
  3. s_prod=1 and s_cons=0: BUBBLE action. The producer is stopped, the consumer proceeds, so a NOP is inserted.
  4. s_prod=1 and s_cons=1: HOLD action. All registers keep their value.
  5. s_prod=0: ADVANCE action. o_valid<=i_valid, o_pc<=i_pc, o_payload<=i_payload.
- BUBBLE action: o_valid<=0, o_pc<=0, o_payload<=0.
- s_prod=0 with s_cons=1 is illegal from a correct stall controller. The block still takes ADVANCE. Simulation assertion flags it.
- Latency: 1 cycle from input to output on ADVANCE.
- o_hold_cnt:
  - Cleared on reset, BUBBLE and ADVANCE.
  - Increments by 1 on HOLD.
  - Saturates at 2^HOLD_W-1 and never wraps.
  - Counts regardless of o_valid.
- A flush arriving during a multi-cycle hold wins. The next cycle shows o_valid=0 and o_hold_cnt=0.
- Reset asserted mid-hold or mid-flush takes effect on that edge; no state survives it.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined:
  - o_bubble_cnt increments on every BUBBLE action caused by rule 3.
  - o_flush_cnt increments on every rule-2 flush whose registered o_valid was 1 at that edge, i.e. a real instruction was killed.
  - Both are 32-bit and wrap modulo 2^32.
- Undefined: both ports are constant 0 and no counter flops are synthesised.
- Ports exist in both builds.

Decomposition:
- Shared package/header (global_define.vh):
  - Stop=1'b1, NoStop=1'b0, ZeroWord=32'h0
  - PIPE_HOLD_W default
  - Stall-vector bit indices per stage: STALL_IF=1, STALL_ID=2, STALL_EX=3, STALL_MEM=4, STALL_WB=5
- Sub-module pipe_sat_counter (WIDTH, clear, inc → count, saturating):
  - Used for o_hold_cnt.
  - Reused with saturation disabled (parameter SAT=0) for the perf counters.

Test Plan:
- Reset then ADVANCE: reset=1 for 2 cycles, then stall=6'b000000, i_valid=1, i_pc=32'h00000100, i_payload=32'h24020001. Required: next cycle o_valid=1, o_pc=32'h100, o_payload=32'h24020001, o_hold_cnt=0.
- Bubble insertion, STAGE=1: with the entry loaded, stall=6'b000011. Required: next cycle o_valid=0, o_pc=0, o_payload=0. With PIPE_PERF_CNT_EN, o_bubble_cnt=1.
- Hold: stall=6'b000111 for 5 cycles. Required: o_pc stays 32'h104 and o_hold_cnt reads 1,2,3,4,5. Releasing to 6'b000000 loads the new i_pc and clears o_hold_cnt.
- Saturation: HOLD_W=3, stall=6'b000111 for 10 cycles. Required: o_hold_cnt stops at 7.
- Flush over stall: during a hold with o_valid=1, pulse flush=1 for 1 cycle. Required: next cycle o_valid=0 and o_hold_cnt=0. With PIPE_PERF_CNT_EN, o_flush_cnt increments by 1. A second flush with o_valid=0 leaves o_flush_cnt unchanged.
- Reset mid-hold: o_hold_cnt=4, o_valid=1, assert reset for 1 cycle while stall=6'b000111. Required: all outputs are 0 on the next edge.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register: stall encodings,
// stall-vector bit indices per stage, and the per-cycle action decode.
package pipe_stage_reg_pkg;

  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0;

  localparam int PIPE_HOLD_W = 8;

  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // Bubbles are split by cause so the perf counters can tell them apart.
  typedef enum logic [1:0] {
    ACT_ADVANCE      = 2'd0,
    ACT_BUBBLE_FLUSH = 2'd1,
    ACT_BUBBLE_STALL = 2'd2,
    ACT_HOLD         = 2'd3
  } pipe_action_e;

  function automatic pipe_action_e decode_action(input logic flush,
                                                 input logic s_prod,
                                                 input logic s_cons);
    pipe_action_e act;
    if (flush)
      act = ACT_BUBBLE_FLUSH;
    else if (s_prod == Stop && s_cons == NoStop)
      act = ACT_BUBBLE_STALL;
    else if (s_prod == Stop)
      act = ACT_HOLD;
    else
      act = ACT_ADVANCE;
    return act;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of stall/flush controls, producer-side inputs and registered outputs
// for one pipeline boundary. No handshake: the stall vector alone decides flow.
interface pipe_stage_reg_if #(
  parameter int STALL_W   = 6,
  parameter int PAYLOAD_W = 32,
  parameter int HOLD_W    = pipe_stage_reg_pkg::PIPE_HOLD_W
);
  logic [STALL_W-1:0]   stall;
  logic                 flush;
  logic                 i_valid;
  logic [31:0]          i_pc;
  logic [PAYLOAD_W-1:0] i_payload;
  logic                 o_valid;
  logic [31:0]          o_pc;
  logic [PAYLOAD_W-1:0] o_payload;
  logic [HOLD_W-1:0]    o_hold_cnt;
  logic [31:0]          o_bubble_cnt;
  logic [31:0]          o_flush_cnt;

  modport master (
    output stall, flush, i_valid, i_pc, i_payload,
    input  o_valid, o_pc, o_payload, o_hold_cnt, o_bubble_cnt, o_flush_cnt
  );

  modport slave (
    input  stall, flush, i_valid, i_pc, i_payload,
    output o_valid, o_pc, o_payload, o_hold_cnt, o_bubble_cnt, o_flush_cnt
  );
endinterface

// File: rtl/pipe_sat_counter.sv
// Up-counter with synchronous clear; saturates at all-ones when SAT=1,
// wraps modulo 2^WIDTH when SAT=0.
module pipe_sat_counter #(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (inc && !(SAT && (&count)))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register between stage STAGE and STAGE+1 with valid bit,
// flush, hold counter. Optional perf counters under `define PIPE_PERF_CNT_EN.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int STAGE     = STALL_IF,
  parameter int STALL_W   = 6,
  parameter int PAYLOAD_W = 32,
  parameter int HOLD_W    = PIPE_HOLD_W
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_stage_reg_if.slave      bus
);

  logic         s_prod;
  logic         s_cons;
  pipe_action_e action;

  logic                 valid_q;
  logic [31:0]          pc_q;
  logic [PAYLOAD_W-1:0] payload_q;

  // Only two stall bits matter here; the rest belong to other boundaries.
  logic unused_stall_bits;
  assign unused_stall_bits = ^bus.stall;

  assign s_prod = bus.stall[STAGE];
  assign s_cons = bus.stall[STAGE+1];

  always_comb action = decode_action(bus.flush, s_prod, s_cons);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= ZeroWord;
      payload_q <= '0;
    end else begin
      case (action)
        ACT_ADVANCE: begin
          valid_q   <= bus.i_valid;
          pc_q      <= bus.i_pc;
          payload_q <= bus.i_payload;
        end
        ACT_BUBBLE_FLUSH, ACT_BUBBLE_STALL: begin
          valid_q   <= 1'b0;
          pc_q      <= ZeroWord;
          payload_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_pc      = pc_q;
  assign bus.o_payload = payload_q;

  pipe_sat_counter #(.WIDTH(HOLD_W), .SAT(1'b1)) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (action != ACT_HOLD),
    .inc   (action == ACT_HOLD),
    .count (bus.o_hold_cnt)
  );

`ifdef PIPE_PERF_CNT_EN
  // A flush only counts as a kill when a real instruction sat in the register.
  pipe_sat_counter #(.WIDTH(32), .SAT(1'b0)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (action == ACT_BUBBLE_STALL),
    .count (bus.o_bubble_cnt)
  );

  pipe_sat_counter #(.WIDTH(32), .SAT(1'b0)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   ((action == ACT_BUBBLE_FLUSH) && valid_q),
    .count (bus.o_flush_cnt)
  );
`else
  assign bus.o_bubble_cnt = 32'h0;
  assign bus.o_flush_cnt  = 32'h0;
`endif

  illegal_stall_combo: assert property (@(posedge clk) disable iff (reset)
    !(s_cons == Stop && s_prod == NoStop));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (HOLD_W=8 and HOLD_W=3) share stimulus
// and are compared every cycle against a rule-level model.
module tb_pipe_stage_reg;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int HOLD_A = 8;
  localparam int HOLD_B = 3;

  logic        clk;
  logic        reset_v;
  logic [5:0]  stall_v;
  logic        flush_v;
  logic        valid_v;
  logic [31:0] pc_v;
  logic [31:0] payload_v;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // model state
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_payload;
  int          m_run;
  logic [31:0] m_bubble;
  logic [31:0] m_flush;

  pipe_stage_reg_if #(.STALL_W(6), .PAYLOAD_W(32), .HOLD_W(HOLD_A)) bus_a ();
  pipe_stage_reg_if #(.STALL_W(6), .PAYLOAD_W(32), .HOLD_W(HOLD_B)) bus_b ();

  assign bus_a.stall = stall_v;   assign bus_b.stall = stall_v;
  assign bus_a.flush = flush_v;   assign bus_b.flush = flush_v;
  assign bus_a.i_valid = valid_v; assign bus_b.i_valid = valid_v;
  assign bus_a.i_pc = pc_v;       assign bus_b.i_pc = pc_v;
  assign bus_a.i_payload = payload_v;
  assign bus_b.i_payload = payload_v;

  pipe_stage_reg #(.STAGE(1), .STALL_W(6), .PAYLOAD_W(32), .HOLD_W(HOLD_A)) dut_a (
    .clk (clk), .reset (reset_v), .bus (bus_a.slave)
  );
  pipe_stage_reg #(.STAGE(1), .STALL_W(6), .PAYLOAD_W(32), .HOLD_W(HOLD_B)) dut_b (
    .clk (clk), .reset (reset_v), .bus (bus_b.slave)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the boundary rules applied directly, hold length kept unbounded.
  always @(posedge clk) begin
    if (reset_v) begin
      m_valid = 1'b0; m_pc = 32'h0; m_payload = 32'h0;
      m_run = 0; m_bubble = 32'h0; m_flush = 32'h0;
    end else if (flush_v) begin
      if (m_valid) m_flush = m_flush + 32'd1;
      m_valid = 1'b0; m_pc = 32'h0; m_payload = 32'h0; m_run = 0;
    end else if (stall_v[1] && !stall_v[2]) begin
      m_bubble = m_bubble + 32'd1;
      m_valid = 1'b0; m_pc = 32'h0; m_payload = 32'h0; m_run = 0;
    end else if (stall_v[1]) begin
      m_run = m_run + 1;
    end else begin
      m_valid = valid_v; m_pc = pc_v; m_payload = payload_v; m_run = 0;
    end
  end

  function automatic int sat_to(input int run, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (run > mx) ? mx : run;
  endfunction

  // scoreboard compare, once per cycle away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      check("a_valid",   {63'h0, bus_a.o_valid}, {63'h0, m_valid});
      check("a_pc",      {32'h0, bus_a.o_pc}, {32'h0, m_pc});
      check("a_payload", {32'h0, bus_a.o_payload}, {32'h0, m_payload});
      check("a_hold",    {56'h0, bus_a.o_hold_cnt}, 64'(sat_to(m_run, HOLD_A)));
      check("a_bubble",  {32'h0, bus_a.o_bubble_cnt}, PERF ? {32'h0, m_bubble} : 64'h0);
      check("a_flushc",  {32'h0, bus_a.o_flush_cnt}, PERF ? {32'h0, m_flush} : 64'h0);
      check("b_valid",   {63'h0, bus_b.o_valid}, {63'h0, m_valid});
      check("b_pc",      {32'h0, bus_b.o_pc}, {32'h0, m_pc});
      check("b_hold",    {61'h0, bus_b.o_hold_cnt}, 64'(sat_to(m_run, HOLD_B)));
      check("b_flushc",  {32'h0, bus_b.o_flush_cnt}, PERF ? {32'h0, m_flush} : 64'h0);
    end
  end

  // driver: apply inputs just after a falling edge, return at the next falling edge
  task automatic step(input logic [5:0] s, input logic f, input logic v,
                      input logic [31:0] pc, input logic [31:0] pl, input logic r);
    reset_v = r; stall_v = s; flush_v = f; valid_v = v; pc_v = pc; payload_v = pl;
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] s;
    logic       prod;

    reset_v = 1'b1; stall_v = 6'b0; flush_v = 1'b0;
    valid_v = 1'b0; pc_v = 32'h0; payload_v = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check_en = 1'b1;
    check("reset_valid", {63'h0, bus_a.o_valid}, 64'h0);
    check("reset_pc", {32'h0, bus_a.o_pc}, 64'h0);

    // reset then advance
    step(6'b000000, 1'b0, 1'b1, 32'h100, 32'h24020001, 1'b0);
    check("adv_valid", {63'h0, bus_a.o_valid}, 64'h1);
    check("adv_pc", {32'h0, bus_a.o_pc}, 64'h100);
    check("adv_payload", {32'h0, bus_a.o_payload}, 64'h24020001);
    check("adv_hold", {56'h0, bus_a.o_hold_cnt}, 64'h0);

    // bubble insertion
    step(6'b000011, 1'b0, 1'b1, 32'h200, 32'h11111111, 1'b0);
    check("bub_valid", {63'h0, bus_a.o_valid}, 64'h0);
    check("bub_pc", {32'h0, bus_a.o_pc}, 64'h0);
    check("bub_cnt", {32'h0, bus_a.o_bubble_cnt}, PERF ? 64'h1 : 64'h0);

    // hold for 5 cycles, then release
    step(6'b000000, 1'b0, 1'b1, 32'h104, 32'hAAAA0104, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(6'b000111, 1'b0, 1'b1, 32'h900 + 32'(i), 32'h0, 1'b0);
      check("hold_pc", {32'h0, bus_a.o_pc}, 64'h104);
      check("hold_cnt", {56'h0, bus_a.o_hold_cnt}, 64'(i));
    end
    step(6'b000000, 1'b0, 1'b1, 32'h108, 32'hAAAA0108, 1'b0);
    check("rel_pc", {32'h0, bus_a.o_pc}, 64'h108);
    check("rel_hold", {56'h0, bus_a.o_hold_cnt}, 64'h0);

    // saturation at 7 on the 3-bit instance
    for (int i = 0; i < 10; i++) step(6'b000111, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("sat_b", {61'h0, bus_b.o_hold_cnt}, 64'h7);
    check("sat_a", {56'h0, bus_a.o_hold_cnt}, 64'd10);

    // flush over stall with a live entry, then again with an empty one
    step(6'b000111, 1'b1, 1'b1, 32'h300, 32'h0, 1'b0);
    check("flush_valid", {63'h0, bus_a.o_valid}, 64'h0);
    check("flush_hold", {56'h0, bus_a.o_hold_cnt}, 64'h0);
    check("flush_cnt1", {32'h0, bus_a.o_flush_cnt}, PERF ? 64'h1 : 64'h0);
    step(6'b000111, 1'b1, 1'b1, 32'h304, 32'h0, 1'b0);
    check("flush_cnt2", {32'h0, bus_a.o_flush_cnt}, PERF ? 64'h1 : 64'h0);

    // reset mid-hold
    step(6'b000000, 1'b0, 1'b1, 32'h400, 32'h55555555, 1'b0);
    for (int i = 0; i < 4; i++) step(6'b000111, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("pre_rst_hold", {56'h0, bus_a.o_hold_cnt}, 64'h4);
    step(6'b000111, 1'b0, 1'b1, 32'h500, 32'h1, 1'b1);
    check("rst_valid", {63'h0, bus_a.o_valid}, 64'h0);
    check("rst_pc", {32'h0, bus_a.o_pc}, 64'h0);
    check("rst_payload", {32'h0, bus_a.o_payload}, 64'h0);
    check("rst_hold", {56'h0, bus_a.o_hold_cnt}, 64'h0);
    check("rst_bubble", {32'h0, bus_a.o_bubble_cnt}, 64'h0);
    check("rst_flushc", {32'h0, bus_a.o_flush_cnt}, 64'h0);

    // random traffic, never presenting consumer-stop with producer-go
    for (int i = 0; i < 400; i++) begin
      s = 6'($urandom_range(0, 63));
      prod = ($urandom_range(0, 2) != 0);
      s[1] = prod;
      s[2] = prod ? 1'($urandom_range(0, 1)) : 1'b0;
      step(s, ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
           $urandom, $urandom, ($urandom_range(0, 59) == 0));
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
